decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered RV decode stage between fetch and issue. Accepts one 32-bit instruction plus PC per beat over
//  valid/ready, extracts opcode/funct3/funct7/rd/rs1/rs2, builds the sign-extended XLEN immediate for all
//  formats (I/S/B/U/J plus CSR zimm), classifies the format and flags illegal encodings. Supports flush.
// PARAMETERS
//  XLEN      32  datapath width, 32 or 64; immediates sign-extend to XLEN, 64 also legalises OP-IMM-32/OP-32
//  SKID      1   1: 2-entry skid buffer (in_ready registered); 0: single output register, in_ready combinational
// PORTS
//  clk           in   1      clock
//  rst_n         in   1      asynchronous active-low reset
//  flush         in   1      discard all held beats (branch mispredict / trap)
//  in_valid      in   1      upstream beat valid
//  in_ready      out  1      stage can accept a beat
//  in_instr      in   32     raw instruction
//  in_pc         in   XLEN   instruction PC
//  out_valid     out  1      decoded beat valid
//  out_ready     in   1      downstream accepts
//  out_pc        out  XLEN   PC passthrough
//  out_opcode    out  7      instr[6:0]
//  out_rd/rs1/rs2 out 5 each instr[11:7]/[19:15]/[24:20]
//  out_funct3    out  3      instr[14:12]
//  out_funct7    out  7      instr[31:25]
//  out_imm       out  XLEN   sign-extended immediate, 0 when out_imm_valid=0
//  out_imm_valid out  1      immediate meaningful for this format
//  out_fmt       out  3      R=0 I=1 S=2 B=3 U=4 J=5 CSR=6 NONE=7
//  out_illegal   out  1      illegal encoding; beat still delivered
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0, in_ready=1, all data outputs 0, skid entry empty.
//  - Transfer on valid&ready at posedge; latency 1 cycle in->out; 1 beat/cycle sustained when out_ready=1.
//  - out_* stable while out_valid&!out_ready; in_valid must not drop before in_ready (upstream rule).
//  - SKID=0: in_ready = !out_valid | out_ready. SKID=1: in_ready = !skid_full (registered); on stall the
//    incoming beat parks in skid; on next out_ready it moves to output; no beat dropped or duplicated.
//  - flush: next edge out_valid=0, skid emptied; beat presented same cycle as flush is discarded; in_ready=1 next.
//  - Formats: OP-IMM/LOAD/JALR/MISC-MEM/OP-IMM-32=I; STORE=S; BRANCH=B; LUI/AUIPC=U (imm={instr[31:12],12'b0}
//    sign-extended); JAL=J; SYSTEM: funct3!=0 -> CSR (imm=zero-extended instr[19:15]), funct3=0 -> I;
//    OP/OP-32=R (imm_valid=0, fmt=R); else NONE.
//  - Illegal when: instr[1:0]!=2'b11; opcode NONE; OP-IMM-32/OP-32 with XLEN=32; JALR funct3!=0;
//    BRANCH funct3 in {2,3}; LOAD funct3=7 or (XLEN=32 and funct3 in {3,6}); STORE funct3>=4 or (XLEN=32 and 3).
//    Illegal beats carry fmt=NONE, imm_valid=0, imm=0.
//  - Shift-immediate encodings pass through unmodified; funct7 legality checked downstream.
//  - Reset mid-transfer: all beats lost, outputs return to reset values asynchronously.
// STRUCTURE
//  - decode_pkg: opcode localparams, fmt encoding, funct3 legality constants; shared with issue stage.
//  - imm_gen (combinational): instr, XLEN -> imm, imm_valid, fmt, illegal; one instance feeds stage regs.
//  - decode_stage: handshake, output regs, optional skid entry, flush.
// TESTING
//  1 0xFFF00093 (addi x1,x0,-1), XLEN=32 -> fmt=I, rd=1, imm=0xFFFFFFFF, imm_valid=1, illegal=0, 1 cycle later.
//  2 0x123452B7 (lui x5,0x12345), XLEN=64 -> fmt=U, rd=5, imm=0x0000000012345000; 0xFE000EE3 -> fmt=B, imm=-4.
//  3 0x00000000 and 0x0000001B (XLEN=32) -> illegal=1, fmt=NONE, imm=0; 0x0000001B with XLEN=64 -> legal I.
//  4 Back-to-back 4 beats, out_ready low cycles 2-3, SKID=1 -> all 4 delivered in order, PCs intact, none dup.
//  5 flush asserted with out_valid=1 and skid full -> next cycle out_valid=0, in_ready=1, no stale beat emerges.
//  6 rst_n pulsed low mid-stream (not on clock edge) -> out_valid=0 immediately; stream resumes cleanly after.

Source files
------------

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pkg
//  Description : Shared RV decode definitions: major opcodes, instruction
//                format encoding and funct3 values relevant to legality.
//                Used by the decode stage and the downstream issue stage.
//  Revision    : 1.0  initial release
// ============================================================================
package decode_pkg;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] c_OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] c_OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] c_OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] c_OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] c_OPC_STORE     = 7'b0100011;
    localparam logic [6:0] c_OPC_OP        = 7'b0110011;
    localparam logic [6:0] c_OPC_LUI       = 7'b0110111;
    localparam logic [6:0] c_OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] c_OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] c_OPC_JALR      = 7'b1100111;
    localparam logic [6:0] c_OPC_JAL       = 7'b1101111;
    localparam logic [6:0] c_OPC_SYSTEM    = 7'b1110011;

    // Instruction format classification carried with each decoded beat
    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_CSR  = 3'd6,
        FMT_NONE = 3'd7
    } fmt_e;

    // funct3 values that matter for legality
    localparam logic [2:0] c_F3_LD_D     = 3'd3;  // LD / SD: RV64 only
    localparam logic [2:0] c_F3_LD_WU    = 3'd6;  // LWU: RV64 only
    localparam logic [2:0] c_F3_LD_RSVD  = 3'd7;  // reserved load width
    localparam logic [2:0] c_F3_BR_RSVD0 = 3'd2;  // reserved branch conditions
    localparam logic [2:0] c_F3_BR_RSVD1 = 3'd3;
    localparam logic [2:0] c_F3_JALR     = 3'd0;  // only legal JALR funct3
    localparam logic [2:0] c_F3_PRIV     = 3'd0;  // SYSTEM non-CSR group

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen
//  Description : Combinational format classifier, immediate generator and
//                illegal-encoding detector for one 32-bit RV instruction.
//  Ports       : instr_i      raw instruction
//                imm_o        immediate extended to XLEN (0 if not valid)
//                imm_valid_o  immediate is meaningful for this format
//                fmt_o        format class (FMT_NONE for illegal beats)
//                illegal_o    encoding is illegal for this XLEN
//  Revision    : 1.0  initial release
// ============================================================================
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output logic            imm_valid_o,
    output fmt_e            fmt_o,
    output logic            illegal_o
);

    localparam bit c_RV32 = (XLEN == 32);

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    fmt_e        w_fmt;
    logic        w_ill;
    logic [31:0] w_imm32;

    assign w_opcode = instr_i[6:0];
    assign w_f3     = instr_i[14:12];

    always_comb begin
        w_fmt   = FMT_NONE;
        w_ill   = 1'b0;
        w_imm32 = '0;

        case (w_opcode)
            c_OPC_OP_IMM, c_OPC_MISC_MEM: w_fmt = FMT_I;
            c_OPC_LOAD: begin
                w_fmt = FMT_I;
                w_ill = (w_f3 == c_F3_LD_RSVD) ||
                        (c_RV32 && ((w_f3 == c_F3_LD_D) || (w_f3 == c_F3_LD_WU)));
            end
            c_OPC_JALR: begin
                w_fmt = FMT_I;
                w_ill = (w_f3 != c_F3_JALR);
            end
            c_OPC_OP_IMM_32: begin
                w_fmt = FMT_I;
                w_ill = c_RV32;
            end
            c_OPC_STORE: begin
                w_fmt = FMT_S;
                w_ill = w_f3[2] || (c_RV32 && (w_f3 == c_F3_LD_D));
            end
            c_OPC_BRANCH: begin
                w_fmt = FMT_B;
                w_ill = (w_f3 == c_F3_BR_RSVD0) || (w_f3 == c_F3_BR_RSVD1);
            end
            c_OPC_LUI, c_OPC_AUIPC: w_fmt = FMT_U;
            c_OPC_JAL:              w_fmt = FMT_J;
            c_OPC_SYSTEM:           w_fmt = (w_f3 == c_F3_PRIV) ? FMT_I : FMT_CSR;
            c_OPC_OP:               w_fmt = FMT_R;
            c_OPC_OP_32: begin
                w_fmt = FMT_R;
                w_ill = c_RV32;
            end
            default: w_ill = 1'b1;
        endcase

        // Compressed / non-32-bit encodings never reach a valid opcode above,
        // but keep the check explicit so the intent survives opcode table edits.
        if (instr_i[1:0] != 2'b11) begin
            w_ill = 1'b1;
        end

        // Illegal beats are stripped to NONE so no immediate leaks downstream.
        if (w_ill) begin
            w_fmt = FMT_NONE;
        end

        case (w_fmt)
            FMT_I:   w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            FMT_S:   w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_B:   w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                instr_i[30:25], instr_i[11:8], 1'b0};
            FMT_U:   w_imm32 = {instr_i[31:12], 12'b0};
            FMT_J:   w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                instr_i[20], instr_i[30:21], 1'b0};
            FMT_CSR: w_imm32 = {27'b0, instr_i[19:15]};   // zimm, zero-extended
            default: w_imm32 = '0;
        endcase
    end

    // Bit 31 of w_imm32 already holds the sign (0 for zimm), so a signed
    // widening cast gives the correct XLEN extension for every format.
    assign imm_o       = XLEN'($signed(w_imm32));
    assign imm_valid_o = (w_fmt != FMT_R) && (w_fmt != FMT_NONE);
    assign fmt_o       = w_fmt;
    assign illegal_o   = w_ill;

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Registered RV decode stage between fetch and issue.
//                One instruction + PC per beat over valid/ready; decodes on
//                entry and registers the result (1-cycle latency). Optional
//                2-entry skid buffer gives a registered in_ready.
//  Ports       : clk, rst_n (async active-low), flush_i
//                in_valid_i/in_ready_o, in_instr_i, in_pc_i   upstream beat
//                out_valid_o/out_ready_i, out_pc_o, out_opcode_o, out_rd_o,
//                out_rs1_o, out_rs2_o, out_funct3_o, out_funct7_o, out_imm_o,
//                out_imm_valid_o, out_fmt_o, out_illegal_o    decoded beat
//  Revision    : 1.0  initial release
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     in_instr_i,
    input  logic [XLEN-1:0] in_pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [6:0]      out_opcode_o,
    output logic [4:0]      out_rd_o,
    output logic [4:0]      out_rs1_o,
    output logic [4:0]      out_rs2_o,
    output logic [2:0]      out_funct3_o,
    output logic [6:0]      out_funct7_o,
    output logic [XLEN-1:0] out_imm_o,
    output logic            out_imm_valid_o,
    output logic [2:0]      out_fmt_o,
    output logic            out_illegal_o
);

    // Beat layout, LSB first: illegal, fmt[2:0], imm_valid, imm, instr, pc
    localparam int c_PW      = 2 * XLEN + 37;
    localparam int c_IMM_LSB = 5;
    localparam int c_INS_LSB = XLEN + 5;
    localparam int c_PC_LSB  = XLEN + 37;

    logic [XLEN-1:0] w_imm;
    logic            w_imm_valid;
    fmt_e            w_fmt;
    logic            w_illegal;
    logic [c_PW-1:0] w_in_beat;
    logic            w_accept;

    logic [c_PW-1:0] out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic [c_PW-1:0] skid_q, skid_d;
    logic            skid_valid_q, skid_valid_d;

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr_i     (in_instr_i),
        .imm_o       (w_imm),
        .imm_valid_o (w_imm_valid),
        .fmt_o       (w_fmt),
        .illegal_o   (w_illegal)
    );

    assign w_in_beat = {in_pc_i, in_instr_i, w_imm, w_imm_valid, w_fmt, w_illegal};

    generate
        if (SKID) begin : g_skid
            // Registered ready: one free skid slot absorbs the beat that was
            // already in flight when the output stalled.
            assign in_ready_o = !skid_valid_q;
        end else begin : g_no_skid
            assign in_ready_o = !out_valid_q || out_ready_i;
        end
    endgenerate

    assign w_accept = in_valid_i && in_ready_o;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (flush_i) begin
            // Drop everything held, including a beat accepted this cycle.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready_i) begin
            // Output slot frees up: the older skid beat has priority. While the
            // skid is full in_ready is low, so no new beat competes with it.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = w_accept;
                if (w_accept) begin
                    out_d = w_in_beat;
                end
            end
        end else if (w_accept) begin
            // Output stalled: park the incoming beat (only reachable with SKID).
            skid_d       = w_in_beat;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid_o     = out_valid_q;
    assign out_pc_o        = out_q[c_PC_LSB +: XLEN];
    assign out_opcode_o    = out_q[c_INS_LSB +: 7];
    assign out_rd_o        = out_q[c_INS_LSB + 7 +: 5];
    assign out_funct3_o    = out_q[c_INS_LSB + 12 +: 3];
    assign out_rs1_o       = out_q[c_INS_LSB + 15 +: 5];
    assign out_rs2_o       = out_q[c_INS_LSB + 20 +: 5];
    assign out_funct7_o    = out_q[c_INS_LSB + 25 +: 7];
    assign out_imm_o       = out_q[c_IMM_LSB +: XLEN];
    assign out_imm_valid_o = out_q[4];
    assign out_fmt_o       = out_q[3:1];
    assign out_illegal_o   = out_q[0];

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Self-checking bench for decode_stage. Two instances are
//                exercised one after the other (XLEN=32/SKID=1 and
//                XLEN=64/SKID=0) against a behavioural decode model and an
//                in-order beat scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n0, rst_n1, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        rdy0, ov0, iv0, ill0, rdy1, ov1, iv1, ill1;
    logic [31:0] pc0, imm0;
    logic [63:0] pc1, imm1;
    logic [6:0]  opc0, f70, opc1, f71;
    logic [4:0]  rd0, rs10, rs20, rd1, rs11, rs21;
    logic [2:0]  f30, fmt0, f31, fmt1;

    decode_stage #(.XLEN(32), .SKID(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n0), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(rdy0), .in_instr_i(in_instr), .in_pc_i(in_pc[31:0]),
        .out_valid_o(ov0), .out_ready_i(out_ready), .out_pc_o(pc0), .out_opcode_o(opc0),
        .out_rd_o(rd0), .out_rs1_o(rs10), .out_rs2_o(rs20), .out_funct3_o(f30),
        .out_funct7_o(f70), .out_imm_o(imm0), .out_imm_valid_o(iv0), .out_fmt_o(fmt0),
        .out_illegal_o(ill0)
    );

    decode_stage #(.XLEN(64), .SKID(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(rdy1), .in_instr_i(in_instr), .in_pc_i(in_pc),
        .out_valid_o(ov1), .out_ready_i(out_ready), .out_pc_o(pc1), .out_opcode_o(opc1),
        .out_rd_o(rd1), .out_rs1_o(rs11), .out_rs2_o(rs21), .out_funct3_o(f31),
        .out_funct7_o(f71), .out_imm_o(imm1), .out_imm_valid_o(iv1), .out_fmt_o(fmt1),
        .out_illegal_o(ill1)
    );

    // Currently active instance (the other one is held in reset)
    int          cur;
    logic        w_rst, w_rdy, w_ov, w_iv, w_ill;
    logic [63:0] w_pc, w_imm;
    logic [31:0] w_flds;
    logic [2:0]  w_fmt;

    always_comb begin
        if (cur == 0) begin
            w_rst = rst_n0; w_rdy = rdy0; w_ov = ov0; w_iv = iv0; w_ill = ill0;
            w_pc  = {32'b0, pc0}; w_imm = {32'b0, imm0}; w_fmt = fmt0;
            w_flds = {f70, rs20, rs10, f30, rd0, opc0};
        end else begin
            w_rst = rst_n1; w_rdy = rdy1; w_ov = ov1; w_iv = iv1; w_ill = ill1;
            w_pc  = pc1; w_imm = imm1; w_fmt = fmt1;
            w_flds = {f71, rs21, rs11, f31, rd1, opc1};
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cfg=%0d got=%0h exp=%0h", tag, cur, got, exp);
        end
    endtask

    function automatic int xlen();
        return (cur == 0) ? 32 : 64;
    endfunction

    function automatic logic [63:0] xmask();
        return (cur == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    // Reference decode from the ISA rules, immediates built arithmetically.
    function automatic void ref_decode(input logic [31:0] ins, input int xl,
                                       output logic [63:0] imm, output logic iv,
                                       output logic [2:0] fmt, output logic ill);
        longint     sx;
        logic [2:0] f3;
        sx  = longint'($signed(ins));
        f3  = ins[14:12];
        ill = 1'b0;
        fmt = 3'd7;
        imm = '0;
        case (ins[6:0])
            7'h13, 7'h0F: fmt = 3'd1;
            7'h03: begin fmt = 3'd1; ill = (f3 == 7) || (xl == 32 && (f3 == 3 || f3 == 6)); end
            7'h67: begin fmt = 3'd1; ill = (f3 != 0); end
            7'h1B: begin fmt = 3'd1; ill = (xl == 32); end
            7'h23: begin fmt = 3'd2; ill = (f3 >= 4) || (xl == 32 && f3 == 3); end
            7'h63: begin fmt = 3'd3; ill = (f3 == 2) || (f3 == 3); end
            7'h37, 7'h17: fmt = 3'd4;
            7'h6F: fmt = 3'd5;
            7'h73: fmt = (f3 != 0) ? 3'd6 : 3'd1;
            7'h33: fmt = 3'd0;
            7'h3B: begin fmt = 3'd0; ill = (xl == 32); end
            default: ill = 1'b1;
        endcase
        if (ill) fmt = 3'd7;
        case (fmt)
            3'd1: imm = sx >>> 20;
            3'd2: imm = ((sx >>> 25) <<< 5) | longint'(ins[11:7]);
            3'd3: imm = ((sx >>> 31) <<< 12) | (longint'(ins[7]) << 11)
                        | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
            3'd4: imm = (sx >>> 12) <<< 12;
            3'd5: imm = ((sx >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
                        | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
            3'd6: imm = longint'(ins[19:15]);
            default: imm = '0;
        endcase
        iv = (fmt != 3'd0) && (fmt != 3'd7);
        if (xl == 32) imm[63:32] = '0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 13))
            0: r[6:0] = 7'h03;   1: r[6:0] = 7'h0F;   2: r[6:0] = 7'h13;
            3: r[6:0] = 7'h17;   4: r[6:0] = 7'h1B;   5: r[6:0] = 7'h23;
            6: r[6:0] = 7'h33;   7: r[6:0] = 7'h37;   8: r[6:0] = 7'h3B;
            9: r[6:0] = 7'h63;   10: r[6:0] = 7'h67;  11: r[6:0] = 7'h6F;
            12: r[6:0] = 7'h73;  default: ;
        endcase
        if ($urandom_range(0, 9) == 0) r[1:0] = 2'($urandom_range(0, 2));
        return r;
    endfunction

    // Scoreboard of beats expected at the output, in order
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } beat_t;

    beat_t       exp_q[$];
    int          n_out = 0;
    int          n_gen = 0;
    logic        acc   = 1'b0;
    logic        st_prev = 1'b0;
    logic [63:0] prev_pc, prev_imm;
    logic [31:0] prev_flds;

    // Monitor: values at a negedge are what the next posedge will transfer.
    initial begin
        beat_t       b;
        logic [63:0] e_imm;
        logic        e_iv, e_ill;
        logic [2:0]  e_fmt;
        forever begin
            @(negedge clk);
            if (!w_rst) begin
                exp_q.delete();
                st_prev = 1'b0;
            end else begin
                if (st_prev) begin
                    chk("hold_valid", w_ov, 1'b1);
                    chk("hold_data", {w_pc, w_imm, w_flds}, {prev_pc, prev_imm, prev_flds});
                end
                st_prev   = w_ov && !out_ready && !flush;
                prev_pc   = w_pc;
                prev_imm  = w_imm;
                prev_flds = w_flds;
                if (w_ov && out_ready && !flush) begin
                    chk("beat_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        b = exp_q.pop_front();
                        ref_decode(b.ins, xlen(), e_imm, e_iv, e_fmt, e_ill);
                        chk("pc", w_pc, b.pc);
                        chk("fields", w_flds, {b.ins[31:25], b.ins[24:20], b.ins[19:15],
                                               b.ins[14:12], b.ins[11:7], b.ins[6:0]});
                        chk("imm", w_imm, e_imm);
                        chk("ctl", {w_iv, w_fmt, w_ill}, {e_iv, e_fmt, e_ill});
                        n_out++;
                    end
                end
                if (flush) exp_q.delete();
                else if (in_valid && w_rdy) exp_q.push_back({in_pc & xmask(), in_instr});
            end
        end
    end

    // One clock of stimulus, entered and left at posedge+1. A beat not yet
    // accepted is held unchanged.
    task automatic cyc(input bit offer, input bit rdy, input bit fl);
        out_ready = rdy;
        flush     = fl;
        if (!in_valid || acc) begin
            if (offer) begin
                in_valid = 1'b1;
                in_instr = rand_instr();
                in_pc    = {$urandom, $urandom};
                n_gen++;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        acc = in_valid && w_rdy;
        @(posedge clk);
        #1;
    endtask

    // Single directed beat into an idle stage with out_ready high.
    task automatic dir(input logic [31:0] ins, input logic [63:0] e_imm,
                       input logic [2:0] e_fmt, input logic e_iv, input logic e_ill);
        out_ready = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_instr  = ins;
        in_pc     = 64'h8000_0000_0000_1000 + 64'(ins[11:7]);
        @(negedge clk);
        chk("dir_in_ready", w_rdy, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc      = 1'b0;
        @(negedge clk);
        chk("dir_latency_valid", w_ov, 1'b1);
        chk("dir_imm", w_imm, e_imm & xmask());
        chk("dir_ctl", {w_iv, w_fmt, w_ill}, {e_iv, e_fmt, e_ill});
        @(posedge clk);
        #1;
    endtask

    task automatic set_rst(input logic v);
        if (cur == 0) rst_n0 = v; else rst_n1 = v;
    endtask

    initial begin
        int n0, g0;
        rst_n0 = 1'b0; rst_n1 = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        cur = 0;
        for (int c = 0; c < 2; c++) begin
            cur = c;
            rst_n0 = 1'b0; rst_n1 = 1'b0;
            in_valid = 1'b0; acc = 1'b0;
            repeat (3) @(posedge clk);
            #1 set_rst(1'b1);
            @(negedge clk);
            chk("rst_out_valid", w_ov, 1'b0);
            chk("rst_in_ready", w_rdy, 1'b1);
            chk("rst_data", {w_pc, w_imm}, 128'd0);
            chk("rst_ctl", {w_flds, w_fmt, w_iv, w_ill}, 37'd0);
            @(posedge clk);
            #1;

            // Directed decodes
            dir(32'hFFF0_0093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b1, 1'b0);  // addi x1,x0,-1
            dir(32'h1234_52B7, 64'h0000_0000_1234_5000, 3'd4, 1'b1, 1'b0);  // lui x5,0x12345
            dir(32'hFE00_0EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b1, 1'b0);  // branch, imm -4
            dir(32'h0000_0000, 64'h0, 3'd7, 1'b0, 1'b1);
            if (c == 0) dir(32'h0000_001B, 64'h0, 3'd7, 1'b0, 1'b1);
            else        dir(32'h0000_001B, 64'h0, 3'd1, 1'b1, 1'b0);

            // Four back-to-back beats with the output stalled for two cycles
            n0 = n_out;
            g0 = n_gen;
            for (int k = 0; k < 14; k++) cyc((n_gen - g0) < 4, !(k == 1 || k == 2), 1'b0);
            chk("b2b_delivered", n_out - n0, 4);
            chk("b2b_drained", exp_q.size(), 0);

            // Randomized traffic with back-pressure and occasional flush
            repeat (300) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                             $urandom_range(0, 40) == 0);

            // Flush while the stage is completely full
            repeat (4) cyc(1'b1, 1'b0, 1'b0);
            chk("full_out_valid", w_ov, 1'b1);
            chk("full_in_ready", w_rdy, 1'b0);
            cyc(1'b1, 1'b0, 1'b1);
            chk("flush_out_valid", w_ov, 1'b0);
            chk("flush_in_ready", w_rdy, 1'b1);
            repeat (6) cyc(1'b0, 1'b1, 1'b0);
            chk("flush_drained", exp_q.size(), 0);

            // Asynchronous reset pulse in the middle of a stream
            repeat (20) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            cyc(1'b1, 1'b0, 1'b0);
            chk("arst_pre_valid", w_ov, 1'b1);
            #2 set_rst(1'b0);
            #1;
            chk("arst_out_valid", w_ov, 1'b0);
            chk("arst_in_ready", w_rdy, 1'b1);
            chk("arst_data", {w_pc, w_imm}, 128'd0);
            in_valid = 1'b0;
            acc      = 1'b0;
            @(negedge clk);
            #2 set_rst(1'b1);
            @(posedge clk);
            #1;
            repeat (120) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                             $urandom_range(0, 60) == 0);
            repeat (8) cyc(1'b0, 1'b1, 1'b0);
            chk("end_drained", exp_q.size(), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
